// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package muldiv_pkg;

  // Iteration count, equal to the operand width. Only 32 is supported.
  localparam int MULDIV_ITER = 32;

  // Request opcodes from the execute stage.
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  // Sequencer states. The NEG states are only reachable in signed builds.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NEG_IN  = 2'd1,
    ST_ITER    = 2'd2,
    ST_NEG_OUT = 2'd3
  } state_e;

  // ALU function selects. These must track the ALU's function table.
  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_ADDU   = 5'h03;
  localparam logic [4:0] FS_SUBU   = 5'h05;

  // Divide ops have op[1] set.
  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  // Signed ops (MULT, DIV) have op[0] clear.
  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: absolute value of both operands and 32/64-bit negate of HI/LO.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module muldiv_signfix (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] a_abs_o,
  output logic [31:0] b_abs_o,
  output logic [31:0] hi_neg_o,
  output logic [31:0] lo_neg_o,
  output logic [63:0] prod_neg_o
);

  // -2^31 negates to itself; downstream treats it as the unsigned 2^31.
  assign a_abs_o    = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign b_abs_o    = b_i[31] ? (~b_i + 32'd1) : b_i;
  assign hi_neg_o   = ~hi_i + 32'd1;
  assign lo_neg_o   = ~lo_i + 32'd1;
  assign prod_neg_o = ~{hi_i, lo_i} + 64'd1;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the shared ALU.
// Latency: done 33 cycles after accept (35 for signed ops, 1 for divide-by-zero).
// Backpressure: none; start is ignored while busy, nothing is queued.
// Config: define MULDIV_SIGNED_EN for signed MULT/DIV (NEG_IN/NEG_OUT + sign-fix).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] alu_s,
  output logic [31:0] alu_t,
  output logic [4:0]  alu_fs,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_y,
  input  logic        alu_c,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic        is_div_q, is_div_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        start_div0;
  logic        start_signed;
  logic        run_signed;
  logic        last_iter;
  logic [31:0] div_s;
  logic        mul_c;

  // Divide by zero is resolved at accept without entering the iteration loop.
  assign start_div0 = op_is_div(op) && (rt == 32'd0);
  assign last_iter  = (cnt_q == LAST_CNT);
  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign div_s      = {hi_q[30:0], lo_q[31]};
  // PASS_S cycles contribute no carry regardless of what the ALU reports.
  assign mul_c      = lo_q[0] & alu_c;

`ifdef MULDIV_SIGNED_EN
  logic        signed_q, signed_d;
  logic        sgn_lo_q, sgn_lo_d;
  logic        sgn_hi_q, sgn_hi_d;
  logic [31:0] rs_abs, rt_abs, hi_neg, lo_neg;
  logic [63:0] prod_neg;

  assign start_signed = op_is_signed(op);
  assign run_signed   = signed_q;

  muldiv_signfix u_signfix (
    .a_i        (rs_q),
    .b_i        (rt_q),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .a_abs_o    (rs_abs),
    .b_abs_o    (rt_abs),
    .hi_neg_o   (hi_neg),
    .lo_neg_o   (lo_neg),
    .prod_neg_o (prod_neg)
  );

  // Remember signedness at accept and the result signs while in NEG_IN.
  always_comb begin
    signed_d = signed_q;
    sgn_lo_d = sgn_lo_q;
    sgn_hi_d = sgn_hi_q;
    if (start && (state_q == ST_IDLE)) begin
      signed_d = start_signed;
    end
    if (state_q == ST_NEG_IN) begin
      sgn_lo_d = rs_q[31] ^ rt_q[31];
      sgn_hi_d = rs_q[31];
    end
  end

  // Sign-tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signed_q <= 1'b0;
      sgn_lo_q <= 1'b0;
      sgn_hi_q <= 1'b0;
    end else begin
      signed_q <= signed_d;
      sgn_lo_q <= sgn_lo_d;
      sgn_hi_q <= sgn_hi_d;
    end
  end
`else
  logic unused_op0;

  // Without signed support op[0] carries no meaning.
  assign start_signed = 1'b0;
  assign run_signed   = 1'b0;
  assign unused_op0   = op[0];
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !start_div0) begin
          state_d = start_signed ? ST_NEG_IN : ST_ITER;
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_NEG_IN:  state_d = ST_ITER;
      ST_NEG_OUT: state_d = ST_IDLE;
`endif
      ST_ITER: begin
        if (last_iter) begin
          state_d = run_signed ? ST_NEG_OUT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive: only ITER uses the ALU; all other cycles pass S=0.
  always_comb begin
    alu_s  = 32'd0;
    alu_t  = 32'd0;
    alu_fs = FS_PASS_S;
    if (state_q == ST_ITER) begin
      if (is_div_q) begin
        alu_s  = div_s;
        alu_t  = rt_q;
        alu_fs = FS_SUBU;
      end else begin
        alu_s  = hi_q;
        alu_t  = rs_q;
        alu_fs = lo_q[0] ? FS_ADDU : FS_PASS_S;
      end
    end
  end

  assign alu_shamt   = 5'd0;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

  // Datapath next-state: operand latch, shift-add / restoring shift-subtract, sign fix.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op_is_div(op);
          rs_d     = rs;
          rt_d     = rt;
          cnt_d    = 6'd0;
          dbz_d    = 1'b0;
          if (start_div0) begin
            hi_d   = rs;
            lo_d   = 32'hFFFF_FFFF;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            hi_d = 32'd0;
            lo_d = op_is_div(op) ? rs : rt;
          end
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_NEG_IN: begin
        rs_d = rs_abs;
        rt_d = rt_abs;
        lo_d = is_div_q ? rs_abs : rt_abs;
      end
      ST_NEG_OUT: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          if (sgn_lo_q) begin
            {hi_d, lo_d} = prod_neg;
          end
        end else begin
          if (sgn_lo_q) lo_d = lo_neg;
          if (sgn_hi_q) hi_d = hi_neg;
        end
      end
`endif
      ST_ITER: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div_q) begin
          // A set hi[31] means the shifted remainder exceeds 32 bits, so it always fits.
          if (hi_q[31] || !alu_c) begin
            hi_d = alu_y;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = div_s;
            lo_d = {lo_q[30:0], 1'b0};
          end
        end else begin
          hi_d = {mul_c, alu_y[31:1]};
          lo_d = {alu_y[0], lo_q[31:1]};
        end
        if (last_iter && !run_signed) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      rs_q     <= 32'd0;
      rt_q     <= 32'd0;
      is_div_q <= 1'b0;
      cnt_q    <= 6'd0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq with a behavioural ALU.
// Expected HI/LO/flag/latency come from a native-arithmetic model pushed to a scoreboard.
// Signed expectations follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] alu_s, alu_t, alu_y;
  logic [4:0]  alu_fs, alu_shamt;
  logic        alu_c;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t scb[$];

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .alu_s       (alu_s),
    .alu_t       (alu_t),
    .alu_fs      (alu_fs),
    .alu_shamt   (alu_shamt),
    .alu_y       (alu_y),
    .alu_c       (alu_c),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Behavioural ALU: ADDU carry-out, SUBU borrow, PASS_S passes S with no carry.
  always_comb begin
    alu_y = alu_s;
    alu_c = 1'b0;
    case (alu_fs)
      5'h03: {alu_c, alu_y} = {1'b0, alu_s} + {1'b0, alu_t};
      5'h05: {alu_c, alu_y} = {1'b0, alu_s} - {1'b0, alu_t};
      default: ;
    endcase
  end

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    bit     sg;
    longint av, bv, q, r, p;
    sg    = SIGNED_EN && (o[0] == 1'b0);
    e.dbz = 1'b0;
    if (o[1] && (b == 32'd0)) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
      e.lat = 1;
      return e;
    end
    e.lat = sg ? 35 : 33;
    av = sg ? longint'($signed(a)) : longint'({32'd0, a});
    bv = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (o[1]) begin
      q    = av / bv;
      r    = av % bv;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      p    = av * bv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Push the expectation and pulse start; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    scb.push_back(model(o, a, b));
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advance negedge by negedge until done is seen or the budget runs out.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    rs    = 32'd0;
    rt    = 32'd0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b want 000", {busy, done, div_by_zero});
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
    end
    checks++;
    if ({alu_s, alu_t, alu_fs, alu_shamt} !== 74'd0) begin
      errors++;
      $display("FAIL reset_alu: s=%h t=%h fs=%h shamt=%h want 0/0/00/00", alu_s, alu_t, alu_fs, alu_shamt);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_multu_max();
    exp_t        e;
    int          dcyc, busy_bad;
    logic [31:0] hc, lc;
    dcyc = 0;
    busy_bad = 0;
    hc = 32'd0;
    lc = 32'd0;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({alu_fs, alu_t} !== {5'h03, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL multu_alu_c1: fs=%h t=%h want 03/ffffffff", alu_fs, alu_t);
    end
    for (int c = 1; c <= 40; c++) begin
      if (busy !== (c <= 32)) busy_bad++;
      if (done === 1'b1 && dcyc == 0) begin
        dcyc = c;
        hc = hi;
        lc = lo;
      end
      @(negedge clk);
    end
    e = scb.pop_front();
    checks++;
    if ({hc, lc} !== {e.hi, e.lo} || {hc, lc} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max: hi=%h lo=%h want %h/%h", hc, lc, e.hi, e.lo);
    end
    checks++;
    if (dcyc != 33) begin
      errors++;
      $display("FAIL multu_done_cycle: got %0d want 33", dcyc);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL multu_busy_window: %0d cycles off want 0", busy_bad);
    end
  endtask

  task automatic test_mult_signed();
    exp_t e;
    int   cyc;
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo, div_by_zero} !== {e.hi, e.lo, e.dbz} || cyc != e.lat) begin
      errors++;
      $display("FAIL mult_m3x7: hi=%h lo=%h dbz=%b cyc=%0d want %h/%h/%b/%0d",
               hi, lo, div_by_zero, cyc, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    issue(2'd3, 32'd100, 32'd7);
    checks++;
    if (alu_fs !== 5'h05) begin
      errors++;
      $display("FAIL divu_alu_fs: got %h want 05", alu_fs);
    end
    wait_done(1, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || {hi, lo} !== {32'd2, 32'd14} || cyc != e.lat) begin
      errors++;
      $display("FAIL divu_100_7: hi=%h lo=%h cyc=%0d want %h/%h/%0d", hi, lo, cyc, e.hi, e.lo, e.lat);
    end
    issue(2'd3, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    wait_done(1, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.lat) begin
      errors++;
      $display("FAIL divu_max_1: hi=%h lo=%h cyc=%0d want %h/%h/%0d", hi, lo, cyc, e.hi, e.lo, e.lat);
    end
  endtask

  task automatic test_div_signed();
    exp_t e;
    int   cyc;
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.lat) begin
      errors++;
      $display("FAIL div_m7_2: hi=%h lo=%h cyc=%0d want %h/%h/%0d", hi, lo, cyc, e.hi, e.lo, e.lat);
    end
  endtask

  task automatic test_div_by_zero();
    exp_t e;
    int   cyc;
    issue(2'd2, 32'd5, 32'd0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_busy: busy=%b want 0", busy);
    end
    wait_done(1, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo, div_by_zero} !== {e.hi, e.lo, e.dbz} || cyc != 1) begin
      errors++;
      $display("FAIL div_5_0: hi=%h lo=%h dbz=%b cyc=%0d want %h/%h/%b/1",
               hi, lo, div_by_zero, cyc, e.hi, e.lo, e.dbz);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({div_by_zero, done} !== 2'b10) begin
      errors++;
      $display("FAIL dbz_hold: dbz/done=%b want 10", {div_by_zero, done});
    end
    issue(2'd3, 32'd100, 32'd7);
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: dbz=%b want 0", div_by_zero);
    end
    wait_done(1, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || cyc != e.lat) begin
      errors++;
      $display("FAIL after_dbz: hi=%h lo=%h cyc=%0d want %h/%h/%0d", hi, lo, cyc, e.hi, e.lo, e.lat);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   cyc;
    issue(2'd1, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    op    = 2'd3;
    rs    = 32'd9;
    rt    = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, cyc);
    e = scb.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || lo !== 32'd42 || cyc != 33) begin
      errors++;
      $display("FAIL ignore_start: hi=%h lo=%h cyc=%0d want %h/%h/33", hi, lo, cyc, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    issue(2'd1, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: activity=%b want 0", seen);
    end
    scb.delete();
  endtask

  task automatic test_random();
    exp_t        e;
    int          cyc;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      issue(o, a, b);
      wait_done(1, cyc);
      e = scb.pop_front();
      checks++;
      if ({hi, lo, div_by_zero} !== {e.hi, e.lo, e.dbz} || cyc != e.lat) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h dbz=%b cyc=%0d want %h/%h/%b/%0d",
                 i, o, a, b, hi, lo, div_by_zero, cyc, e.hi, e.lo, e.dbz, e.lat);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_back_to_back();
    test_div_signed();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
